ram_sync: RTL and testbench

RAM_SYNC -- requirements
Module: ram_sync

---
 rtl/ram_sync_pkg.sv | 17 +
 rtl/ram_sync_array.sv | 43 ++++
 rtl/ram_sync.sv | 139 +++++++++++++
 tb/tb_ram_sync.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sync_pkg.sv
// ram_sync_pkg -- shared definitions for the ram_sync block.
//   state_t      : FSM encoding (IDLE=0, CLEAR=1)
//   DEF_DATA_W   : default data word width
//   DEF_ADDR_W   : default address width
//   DEF_DEPTH    : default number of words (2**DEF_ADDR_W)
package ram_sync_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

endpackage : ram_sync_pkg

// File: rtl/ram_sync_array.sv
// ram_sync_array -- storage for ram_sync: one synchronous write port and
// one registered read port. The array itself is never reset; only the read
// output register is, so the response data starts at zero.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata : write port, written on the rising edge
//   re, raddr  : read enable/address; rdata loads on the rising edge
//   rdata      : registered read data, holds while re is low
module ram_sync_array
   import ram_sync_pkg::*;
#(
   parameter int WIDTH  = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule : ram_sync_array

// File: rtl/ram_sync.sv
// ram_sync -- single-port synchronous RAM with a hardware clear sequence.
// Optional feature macro: RAM_PARITY_EN (adds a stored even-parity bit per
// word plus the inj_par / par_err ports).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on state and clear, never
// on req_valid. Reads answer with a single-cycle rsp_valid pulse on the
// cycle after acceptance; there is no response backpressure.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake
//   req_wen              : 1 = write, 0 = read
//   req_addr, req_wdata  : word address, write data
//   clear                : start a full-memory clear (sampled in IDLE)
//   busy                 : high while the clear runs (this is the FSM state)
//   rsp_valid, rsp_rdata : read response pulse and data (data holds)
//   inj_par, par_err     : parity inject / parity error (RAM_PARITY_EN only)
module ram_sync
   import ram_sync_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter bit CLR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              clear,
   output logic              busy,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata
`ifdef RAM_PARITY_EN
   ,
   input  logic              inj_par,
   output logic              par_err
`endif
);

`ifdef RAM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;

   logic              accept;
   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_waddr;
   logic [MEM_W-1:0]  mem_wdata;
   logic [MEM_W-1:0]  wr_word;
   logic [MEM_W-1:0]  arr_rdata;

   assign req_ready = (state == IDLE) && !clear;
   assign busy      = (state == CLEAR);
   assign accept    = req_valid && req_ready;
   assign mem_re    = accept && !req_wen;

`ifdef RAM_PARITY_EN
   // Stored bit is even parity of the data, optionally flipped to let a
   // test provoke a parity error on the next read of this word.
   assign wr_word = {(^req_wdata) ^ inj_par, req_wdata};
`else
   assign wr_word = req_wdata;
`endif

   // The clear sequence owns the write port; requests are never accepted
   // in CLEAR, so there is no arbitration beyond the state.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = req_addr;
      mem_wdata = '0;
      if (state == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt;
      end else if (accept && req_wen) begin
         mem_we    = 1'b1;
         mem_wdata = wr_word;
      end
   end

   ram_sync_array #(
      .WIDTH  (MEM_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (req_addr),
      .rdata (arr_rdata)
   );

   assign rsp_rdata = arr_rdata[DATA_W-1:0];

`ifdef RAM_PARITY_EN
   // Qualified by rsp_valid so par_err is zero outside a response and
   // while reset holds rsp_valid low.
   assign par_err = rsp_valid && ((^arr_rdata[DATA_W-1:0]) != arr_rdata[DATA_W]);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLR_ON_RST ? CLEAR : IDLE;
         clr_cnt   <= '0;
         rsp_valid <= 1'b0;
      end else begin
         rsp_valid <= mem_re;
         case (state)
            IDLE: begin
               if (clear) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end
            end
            CLEAR: begin
               // clear is ignored here; the counter only runs forward.
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_ADDR) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule : ram_sync

// File: tb/tb_ram_sync.sv
// tb_ram_sync -- directed bench for ram_sync with a response scoreboard.
// Define RAM_PARITY_EN for both bench and RTL to exercise the parity path.
module tb_ram_sync;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_wen = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              clear = 1'b0;
   logic              busy;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
`ifdef RAM_PARITY_EN
   logic              inj_par = 1'b0;
   logic              par_err;
`endif

   ram_sync dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .clear     (clear),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata)
`ifdef RAM_PARITY_EN
      ,
      .inj_par   (inj_par),
      .par_err   (par_err)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [DATA_W:0] exp_q[$];     // {expected par_err, expected rdata}
   int              exp_cyc_q[$]; // cycle on which the pulse must appear
   logic [DATA_W:0] mon_e;
   int              mon_c;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               flag("unexpected_rsp_valid");
            end else begin
               mon_e = exp_q.pop_front();
               mon_c = exp_cyc_q.pop_front();
               check("rsp_latency", cyc, mon_c);
               check("rsp_rdata", rsp_rdata, mon_e[DATA_W-1:0]);
`ifdef RAM_PARITY_EN
               check("par_err", par_err, mon_e[DATA_W]);
`endif
            end
         end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            flag("rsp_missing");
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic wen, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, input logic inj,
                            input logic clr, input logic exp_ready);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wd;
      clear     = clr;
`ifdef RAM_PARITY_EN
      inj_par   = inj;
`else
      if (inj) $display("note: inj ignored without parity");
`endif
      #1;
      check("req_ready", req_ready, exp_ready);
   endtask

   task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                             input logic inj);
      drive_req(1'b1, addr, wd, inj, 1'b0, 1'b1);
   endtask

   task automatic read_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp_d,
                            input logic exp_p);
      drive_req(1'b0, addr, '0, 1'b0, 1'b0, 1'b1);
      exp_q.push_back({exp_p, exp_d});
      exp_cyc_q.push_back(cyc + 1);
   endtask

   task automatic idle_bus();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wen   = 1'b0;
      clear     = 1'b0;
`ifdef RAM_PARITY_EN
      inj_par   = 1'b0;
`endif
   endtask

   // Counts consecutive busy cycles from the next falling edge; optionally
   // pokes clear part-way through to confirm it is ignored.
   task automatic count_busy(input string name, input int exp_len, input int poke_at);
      int   n = 0;
      logic ready_seen = 1'b0;
      for (int guard = 0; guard < 400; guard++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (req_ready) ready_seen = 1'b1;
         clear = (poke_at >= 0 && n == poke_at);
      end
      clear = 1'b0;
      check(name, n, exp_len);
      check({name, "_ready_low"}, ready_seen, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b1);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 16'h0000);

      @(posedge clk);
      #1 rst_n = 1'b1;
      count_busy("reset_clear_len", DEPTH, -1);

      // cleared memory reads as zero
      read_word(8'h00, 16'h0000, 1'b0);
      read_word(8'h7F, 16'h0000, 1'b0);
      read_word(8'hFF, 16'h0000, 1'b0);

      // write then read of the same address on the next cycle
      write_word(8'h12, 16'hBEEF, 1'b0);
      read_word(8'h12, 16'hBEEF, 1'b0);

      // eight writes then eight back-to-back reads
      for (int a = 0; a < 8; a++) write_word(ADDR_W'(a), 16'h0100 + DATA_W'(a), 1'b0);
      for (int a = 0; a < 8; a++) read_word(ADDR_W'(a), 16'h0100 + DATA_W'(a), 1'b0);
      read_word(8'h12, 16'hBEEF, 1'b0);

      // clear beats a simultaneous write; clear during CLEAR is ignored
      drive_req(1'b1, 8'h05, 16'h1234, 1'b0, 1'b1, 1'b0);
      idle_bus();
      count_busy("clear_len", DEPTH, 50);
      read_word(8'h05, 16'h0000, 1'b0);
      read_word(8'h12, 16'h0000, 1'b0);

      // leave non-zero read data, then reset in the middle of a clear
      write_word(8'h40, 16'h5A5A, 1'b0);
      read_word(8'h40, 16'h5A5A, 1'b0);
      idle_bus();
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midclr_rst_rsp_valid", rsp_valid, 1'b0);
      check("midclr_rst_rsp_rdata", rsp_rdata, 16'h0000);
      check("midclr_rst_busy", busy, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      count_busy("midclr_restart_len", DEPTH, -1);
      read_word(8'h40, 16'h0000, 1'b0);

      // reset while a read response is on the bus
      write_word(8'h33, 16'hA5A5, 1'b0);
      drive_req(1'b0, 8'h33, '0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("midrd_rsp_valid", rsp_valid, 1'b1);
      check("midrd_rsp_rdata", rsp_rdata, 16'hA5A5);
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      check("midrd_rst_rsp_valid", rsp_valid, 1'b0);
      check("midrd_rst_rsp_rdata", rsp_rdata, 16'h0000);
      @(posedge clk);
      #1 rst_n = 1'b1;
      count_busy("midrd_restart_len", DEPTH, -1);
      read_word(8'h33, 16'h0000, 1'b0);

`ifdef RAM_PARITY_EN
      write_word(8'h20, 16'h00FF, 1'b1);
      read_word(8'h20, 16'h00FF, 1'b1);
      write_word(8'h20, 16'h00FF, 1'b0);
      read_word(8'h20, 16'h00FF, 1'b0);
      write_word(8'h21, 16'h0001, 1'b0);
      read_word(8'h21, 16'h0001, 1'b0);
`endif

      idle_bus();
      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_ram_sync
